// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - MIPS HI/LO multiply/divide sequencer
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixup in a final cycle.
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issueValid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] readData,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP
    } state_t;

    state_t             state;
    logic               is_div;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done_q;

    logic             in_set;
    logic             signed_op;
    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        in_set    = 1'b0;
        signed_op = 1'b0;
        case (funct)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULTU, F_DIVU: in_set = 1'b1;
            F_MULT, F_DIV: begin
                in_set    = 1'b1;
                signed_op = 1'b1;
            end
            default: in_set = 1'b0;
        endcase
    end

    assign accept = issueValid && in_set && (state == S_IDLE) && !flush;
    assign a_neg  = signed_op && rsData[WIDTH-1];
    assign b_neg  = signed_op && rtData[WIDTH-1];
    assign a_mag  = a_neg ? (~rsData + 1'b1) : rsData;
    assign b_mag  = b_neg ? (~rtData + 1'b1) : rtData;

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; a carry out of the shift always permits subtraction.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= opnd);
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    assign fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            is_div <= 1'b0;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (funct)
                            F_MTHI: hi <= rsData;
                            F_MTLO: lo <= rsData;
                            F_MULT, F_MULTU: begin
                                state  <= S_MUL;
                                is_div <= 1'b0;
                                count  <= '0;
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                opnd   <= a_mag;
                                sign_a <= a_neg;
                                sign_b <= b_neg;
                            end
                            F_DIV, F_DIVU: begin
                                state  <= S_DIV;
                                is_div <= 1'b1;
                                count  <= '0;
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                opnd   <= b_mag;
                                sign_a <= a_neg;
                                sign_b <= b_neg;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= (state == S_MUL) ? mul_next : div_next;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1))
                            state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi     <= fix_hi;
                        lo     <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = done_q;
    assign stall = issueValid && in_set && busy;
    assign hiOut = hi;
    assign loOut = lo;

    always_comb begin
        readData = '0;
        if (issueValid && funct == F_MFHI)
            readData = hi;
        else if (issueValid && funct == F_MFLO)
            readData = lo;
    end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - self-checking bench for hilo_muldiv_sequencer
module tb_hilo_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] read_data, hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    hilo_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .issueValid(issue_valid), .funct(funct),
        .rsData(rs_data), .rtData(rt_data), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .readData(read_data),
        .hiOut(hi_out), .loOut(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference result {HI, LO} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: return 64'(sa * sb);
            6'h19: return {32'h0, a} * {32'h0, b};
            6'h1B: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) begin
                    q = 32'hFFFFFFFF;
                    r = a[31] ? -a : a;
                    if (a[31]) begin
                        q = -q;
                        r = -r;
                    end
                    return {r, q};
                end
                qq = sa / sb;
                rr = sa % sb;
                return {rr[31:0], qq[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int n;
        e = model(f, a, b);
        @(negedge clk);
        issue_valid = 1'b1; funct = f; rs_data = a; rt_data = b;
        #1 check({tag, " stall_at_issue"}, 32'(stall), 32'h0);
        @(negedge clk);
        issue_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        check({tag, " done"}, 32'(done), 32'h1);
        check({tag, " hi"}, hi_out, e[63:32]);
        check({tag, " lo"}, lo_out, e[31:0]);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(done), 32'h0);
    endtask

    initial begin
        logic [63:0] e;
        logic [5:0]  f;
        logic [31:0] a, b;
        int n;

        // Reset state
        #12;
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset hi", hi_out, 32'h0);
        check("reset lo", lo_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // MTLO then MFLO
        @(negedge clk);
        issue_valid = 1'b1; funct = 6'h13; rs_data = 32'h12345678;
        @(negedge clk);
        funct = 6'h12;
        #1 check("mflo readData", read_data, 32'h12345678);
        check("mtlo hiOut", hi_out, 32'h0);
        check("mtlo busy", 32'(busy), 32'h0);
        issue_valid = 1'b0;
        #1 check("readData idle", read_data, 32'h0);

        // Directed arithmetic cases
        run_op(6'h18, 32'hFFFFFFFD, 32'd7, "mult_m3x7");
        run_op(6'h19, 32'hFFFFFFFD, 32'd7, "multu_m3x7");
        run_op(6'h1B, 32'd100, 32'd7, "divu_100_7");
        run_op(6'h1A, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        run_op(6'h1B, 32'd5, 32'd0, "divu_5_0");
        run_op(6'h1A, 32'hFFFFFFF9, 32'd0, "div_m7_0");
        run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(6'h18, 32'h80000000, 32'h80000000, "mult_minmin");

        // MTHI and MFHI
        @(negedge clk);
        issue_valid = 1'b1; funct = 6'h11; rs_data = 32'hCAFEF00D;
        @(negedge clk);
        funct = 6'h10;
        #1 check("mfhi readData", read_data, 32'hCAFEF00D);
        exp_hi = 32'hCAFEF00D;

        // Unlisted funct is ignored in idle
        funct = 6'h20;
        @(negedge clk);
        check("bad funct no busy", 32'(busy), 32'h0);
        check("bad funct no stall", 32'(stall), 32'h0);
        issue_valid = 1'b0;

        // MFLO presented 5 cycles after a MULT accept
        e = model(6'h18, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        issue_valid = 1'b1; funct = 6'h18; rs_data = 32'hFFFFFFFD; rt_data = 32'd7;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        issue_valid = 1'b1; funct = 6'h21;
        #1 check("bad funct busy no stall", 32'(stall), 32'h0);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        issue_valid = 1'b1; funct = 6'h12;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            #1 check("mflo stall while busy", 32'(stall), 32'h1);
            n++;
            @(negedge clk);
        end
        check("mflo stalled cycles", 32'(n), 32'd29);
        #1 check("mflo done cycle stall", 32'(stall), 32'h0);
        check("mflo done cycle done", 32'(done), 32'h1);
        check("mflo done cycle readData", read_data, e[31:0]);
        issue_valid = 1'b0;
        exp_hi = e[63:32];
        exp_lo = e[31:0];

        // Flush at iteration 10 of DIV
        @(negedge clk);
        issue_valid = 1'b1; funct = 6'h1A; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'h0);
        check("flush done", 32'(done), 32'h0);
        check("flush hi", hi_out, exp_hi);
        check("flush lo", lo_out, exp_lo);
        @(negedge clk);
        check("flush no late done", 32'(done), 32'h0);

        // flush together with an accept in idle: not accepted
        issue_valid = 1'b1; funct = 6'h19; rs_data = 32'd9; rt_data = 32'd9; flush = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0; flush = 1'b0;
        check("flush beats accept", 32'(busy), 32'h0);

        // Reset mid-MUL
        @(negedge clk);
        issue_valid = 1'b1; funct = 6'h18; rs_data = 32'h00012345; rt_data = 32'h00000321;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst hi", hi_out, 32'h0);
        check("rst lo", lo_out, 32'h0);
        check("rst stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_op(6'h18, 32'h00012345, 32'h00000321, "mult_after_rst");

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'h0;
            else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(f, a, b, $sformatf("rand%0d_f%h", i, f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
